// File: rtl/uart_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_sched                                                 |
// | Purpose  : Arbitrates NREQ requesters that each present a 64-bit word,   |
// |            loads the winner into a shared byte serializer and paces its  |
// |            8 bytes (LSB byte first) through one byte-wide UART TX.       |
// | Ports    : clk, rst (async, active high)                                 |
// |            req/req_data/ack   - requester side (level req, ack pulse)    |
// |            ser_start/ser_data/ser_valid/ser_byte/ser_next - serializer   |
// |            tx_start/tx_byte/tx_busy - UART byte transmitter              |
// |            busy, grant_id, err (sticky timeout) - status                 |
// | Macro    : UART_TX_SCHED_RR_EN - round-robin arbitration when defined,   |
// |            fixed priority (lowest index wins) otherwise.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_tx_sched #(
    parameter int NREQ     = 4,
    parameter int WAIT_MAX = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*64-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    output logic               ser_start,
    output logic [64:0]        ser_data,
    input  logic               ser_valid,
    input  logic [7:0]         ser_byte,
    output logic               ser_next,
    output logic               tx_start,
    output logic [7:0]         tx_byte,
    input  logic               tx_busy,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic               err
);

    localparam int c_WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(WAIT_MAX - 1);

    localparam logic [2:0] c_IDLE         = 3'd0;
    localparam logic [2:0] c_LOAD         = 3'd1;
    localparam logic [2:0] c_WAIT_BYTE    = 3'd2;
    localparam logic [2:0] c_WAIT_IDLE_TX = 3'd3;
    localparam logic [2:0] c_TX_RUN       = 3'd4;
    localparam logic [2:0] c_TX_WAIT      = 3'd5;
    localparam logic [2:0] c_FLUSH        = 3'd6;

    logic [2:0]          r_state;
    logic [NREQ-1:0]     r_ack;
    logic                r_ser_start;
    logic [63:0]         r_word;
    logic                r_ser_next;
    logic                r_tx_start;
    logic [7:0]          r_tx_byte;
    logic [2:0]          r_grant;
    logic                r_err;
    logic [2:0]          r_byte_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;

    logic [2:0]          w_state_nxt;
    logic [NREQ-1:0]     w_ack_nxt;
    logic                w_ser_start_nxt;
    logic [63:0]         w_word_nxt;
    logic                w_ser_next_nxt;
    logic                w_tx_start_nxt;
    logic [7:0]          w_tx_byte_nxt;
    logic [2:0]          w_grant_nxt;
    logic                w_err_nxt;
    logic [2:0]          w_byte_cnt_nxt;
    logic [c_WAIT_W-1:0] w_wait_cnt_nxt;

    logic                w_any;
    logic [2:0]          w_winner;
    logic [63:0]         w_sel_word;

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
`ifdef UART_TX_SCHED_RR_EN
    logic [2:0] r_rr_ptr;
    logic       w_hi_any;
    logic [2:0] w_hi;
    logic [2:0] w_lo;

    // Lowest requester at or above the pointer wins; if none, wrap to the
    // lowest requester overall. Avoids a modulo on a non power-of-two NREQ.
    always_comb begin
        w_any    = 1'b0;
        w_hi_any = 1'b0;
        w_hi     = 3'd0;
        w_lo     = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_any = 1'b1;
                w_lo  = 3'(i);
                if (3'(i) >= r_rr_ptr) begin
                    w_hi_any = 1'b1;
                    w_hi     = 3'(i);
                end
            end
        end
        w_winner = w_hi_any ? w_hi : w_lo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 3'd0;
        end else if (r_state == c_IDLE && w_any) begin
            r_rr_ptr <= (w_winner == 3'(NREQ - 1)) ? 3'd0 : w_winner + 3'd1;
        end
    end
`else
    always_comb begin
        w_any    = 1'b0;
        w_winner = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_any    = 1'b1;
                w_winner = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        w_sel_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == 3'(i)) begin
                w_sel_word = req_data[i*64 +: 64];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output logic. Every pulse output is a
    // register, so a decision taken in one cycle is visible the next.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_ack_nxt       = '0;
        w_ser_start_nxt = 1'b0;
        w_ser_next_nxt  = 1'b0;
        w_tx_start_nxt  = 1'b0;
        w_word_nxt      = r_word;
        w_tx_byte_nxt   = r_tx_byte;
        w_grant_nxt     = r_grant;
        w_err_nxt       = r_err;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_wait_cnt_nxt  = r_wait_cnt;

        case (r_state)
            c_IDLE: begin
                if (w_any) begin
                    w_word_nxt  = w_sel_word;
                    w_ack_nxt   = NREQ'(1) << w_winner;
                    w_grant_nxt = w_winner;
                    w_state_nxt = c_LOAD;
                end
            end

            c_LOAD: begin
                w_ser_start_nxt = 1'b1;
                w_wait_cnt_nxt  = '0;
                w_byte_cnt_nxt  = 3'd0;
                w_state_nxt     = c_WAIT_BYTE;
            end

            c_WAIT_BYTE: begin
                // ser_valid is checked before the timeout so it wins a tie.
                if (ser_valid) begin
                    w_tx_byte_nxt = ser_byte;
                    // With the UART already idle, start straight away so the
                    // byte leaves one cycle after ser_valid.
                    if (!tx_busy) begin
                        w_tx_start_nxt = 1'b1;
                        w_state_nxt    = c_TX_RUN;
                    end else begin
                        w_state_nxt    = c_WAIT_IDLE_TX;
                    end
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + c_WAIT_W'(1);
                end
            end

            c_WAIT_IDLE_TX: begin
                if (!tx_busy) begin
                    w_tx_start_nxt = 1'b1;
                    w_state_nxt    = c_TX_RUN;
                end
            end

            // One cycle of grace for the UART to raise tx_busy.
            c_TX_RUN: begin
                w_state_nxt = c_TX_WAIT;
            end

            c_TX_WAIT: begin
                if (!tx_busy) begin
                    // The same ser_next pulse either fetches the next byte or,
                    // after the eighth, lets the serializer drop its busy.
                    w_ser_next_nxt = 1'b1;
                    if (r_byte_cnt == 3'd7) begin
                        w_state_nxt = c_FLUSH;
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + 3'd1;
                        w_wait_cnt_nxt = '0;
                        w_state_nxt    = c_WAIT_BYTE;
                    end
                end
            end

            c_FLUSH: begin
                w_state_nxt = c_IDLE;
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_ack       <= '0;
            r_ser_start <= 1'b0;
            r_word      <= '0;
            r_ser_next  <= 1'b0;
            r_tx_start  <= 1'b0;
            r_tx_byte   <= 8'd0;
            r_grant     <= 3'd0;
            r_err       <= 1'b0;
            r_byte_cnt  <= 3'd0;
            r_wait_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ack       <= w_ack_nxt;
            r_ser_start <= w_ser_start_nxt;
            r_word      <= w_word_nxt;
            r_ser_next  <= w_ser_next_nxt;
            r_tx_start  <= w_tx_start_nxt;
            r_tx_byte   <= w_tx_byte_nxt;
            r_grant     <= w_grant_nxt;
            r_err       <= w_err_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
        end
    end

    assign ack       = r_ack;
    assign ser_start = r_ser_start;
    assign ser_data  = {1'b0, r_word};
    assign ser_next  = r_ser_next;
    assign tx_start  = r_tx_start;
    assign tx_byte   = r_tx_byte;
    assign busy      = (r_state != c_IDLE);
    assign grant_id  = r_grant;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_tx_sched                                              |
// | Purpose  : Directed self-checking bench for uart_tx_sched with simple    |
// |            serializer and UART byte-TX models.                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_tx_sched;

    localparam int NREQ     = 4;
    localparam int WAIT_MAX = 16;
`ifdef UART_TX_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*64-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic               ser_start;
    logic [64:0]        ser_data;
    logic               ser_valid;
    logic [7:0]         ser_byte;
    logic               ser_next;
    logic               tx_start;
    logic [7:0]         tx_byte;
    logic               tx_busy;
    logic               busy;
    logic [2:0]         grant_id;
    logic               err;

    uart_tx_sched #(.NREQ(NREQ), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .ser_start(ser_start), .ser_data(ser_data), .ser_valid(ser_valid),
        .ser_byte(ser_byte), .ser_next(ser_next), .tx_start(tx_start),
        .tx_byte(tx_byte), .tx_busy(tx_busy), .busy(busy),
        .grant_id(grant_id), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- serializer model ----------------
    bit          ser_mute;
    bit          inject_aa;
    logic [63:0] sm_word;
    int          sm_idx;
    int          sm_dly;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_valid <= 1'b0;
            ser_byte  <= 8'd0;
            sm_word   <= '0;
            sm_idx    <= 0;
            sm_dly    <= 0;
        end else begin
            ser_valid <= 1'b0;
            if (ser_start) begin
                sm_word <= ser_data[63:0];
                sm_idx  <= 0;
                sm_dly  <= 2;
            end else if (ser_next) begin
                if (sm_idx < 7) begin
                    sm_idx <= sm_idx + 1;
                    sm_dly <= 2;
                end else begin
                    sm_dly <= 0;
                end
            end else if (sm_dly > 0) begin
                sm_dly <= sm_dly - 1;
                if (sm_dly == 1 && !ser_mute) begin
                    ser_valid <= 1'b1;
                    ser_byte  <= sm_word[8*sm_idx +: 8];
                end
            end
            if (inject_aa) begin
                ser_valid <= 1'b1;
                ser_byte  <= 8'hAA;
            end
        end
    end

    // ---------------- UART model (busy 10 cycles) ----------------
    bit         uart_hold;
    int         um_cnt;
    logic [7:0] um_byte;
    logic [7:0] sent[$];
    int         stab_err = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            um_cnt  <= 0;
            um_byte <= 8'd0;
        end else begin
            if (um_cnt > 0 && tx_byte !== um_byte) stab_err <= stab_err + 1;
            if (tx_start) begin
                sent.push_back(tx_byte);
                um_byte <= tx_byte;
                um_cnt  <= 10;
            end else if (um_cnt > 0) begin
                um_cnt <= um_cnt - 1;
            end
        end
    end
    assign tx_busy = uart_hold | (um_cnt > 0);

    // ---------------- pulse counters ----------------
    int n_sn = 0;
    int n_ts = 0;
    always @(posedge clk) begin
        if (!rst && ser_next) n_sn = n_sn + 1;
        if (!rst && tx_start) n_ts = n_ts + 1;
    end

    // ---------------- checking helpers ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_chk++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, want);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin tick(); n++; end
        chk(tag, 64'(busy), 64'd0);
    endtask

    task automatic wait_sv(input string tag);
        int n = 0;
        while (ser_valid !== 1'b1 && n < 200) begin tick(); n++; end
        chk(tag, 64'(ser_valid), 64'd1);
    endtask

    task automatic wait_ack();
        int n = 0;
        while (ack === '0 && n < 2000) begin tick(); n++; end
    endtask

    task automatic wait_sent(input int base, input int cnt);
        int n = 0;
        while (sent.size() - base < cnt && n < 2000) begin tick(); n++; end
    endtask

    function automatic logic [63:0] stream(input int base);
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++)
            if (base + i < sent.size()) v[8*i +: 8] = sent[base + i];
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, required finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int          base;
        int          sn0;
        int          ts0;
        logic [2:0]  exp_id;
        logic [63:0] words [NREQ];

        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        ser_mute  = 1'b0;
        inject_aa = 1'b0;
        uart_hold = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_ack",   64'(ack), 64'd0);
        chk("rst_sdata", 64'(ser_data[63:0]), 64'd0);
        chk("rst_err",   64'(err), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        rst = 1'b0;
        tick();

        // T1: single word, full 8-byte stream
        base = sent.size(); sn0 = n_sn; ts0 = n_ts;
        req_data[63:0] = 64'h8877665544332211;
        req = 4'b0001;
        tick();
        chk("t1_ack",      64'(ack), 64'h1);
        chk("t1_grant",    64'(grant_id), 64'd0);
        chk("t1_sdata",    ser_data[63:0], 64'h8877665544332211);
        chk("t1_sdata64",  64'(ser_data[64]), 64'd0);
        req = '0;
        tick();
        chk("t1_ser_start", 64'(ser_start), 64'd1);
        wait_sv("t1_sv");
        tick();
        chk("t1_tx_start_lat", 64'(tx_start), 64'd1);
        chk("t1_byte0",        64'(tx_byte), 64'h11);
        wait_idle("t1_done");
        chk("t1_count",    64'(sent.size() - base), 64'd8);
        chk("t1_stream",   stream(base), 64'h8877665544332211);
        chk("t1_ser_next", 64'(n_sn - sn0), 64'd8);
        chk("t1_tx_start", 64'(n_ts - ts0), 64'd8);

        // T2: two requesters held
        words[0] = 64'hA0A0A0A0A0A0A0A0;
        words[1] = 64'hB1B1B1B1B1B1B1B1;
        words[2] = 64'hC2C2C2C2C2C2C2C2;
        words[3] = 64'hD3D3D3D3D3D3D3D3;
        req_data = {words[3], words[2], words[1], words[0]};
        req = 4'b1010;
        for (int g = 0; g < 5; g++) begin
            wait_ack();
            if (g == 4)       exp_id = 3'd3;
            else if (RR)      exp_id = (g % 2 == 1) ? 3'd3 : 3'd1;
            else              exp_id = 3'd1;
            chk($sformatf("t2_grant%0d", g), 64'(grant_id), 64'(exp_id));
            chk($sformatf("t2_ack%0d", g),   64'(ack), 64'd1 << exp_id);
            chk($sformatf("t2_word%0d", g),  ser_data[63:0], words[exp_id]);
            if (g == 3) req = 4'b1000;
            if (g == 4) req = 4'b0000;
            tick();
        end
        wait_idle("t2_done");

        // T3: serializer never answers -> timeout
        ser_mute = 1'b1;
        ts0 = n_ts;
        req_data[63:0] = 64'h0102030405060708;
        req = 4'b0001;
        tick();
        chk("t3_ack", 64'(ack), 64'h1);
        req = '0;
        tick();
        chk("t3_ser_start", 64'(ser_start), 64'd1);
        repeat (WAIT_MAX - 1) tick();
        chk("t3_pre_err",  64'(err), 64'd0);
        chk("t3_pre_busy", 64'(busy), 64'd1);
        tick();
        chk("t3_err",   64'(err), 64'd1);
        chk("t3_idle",  64'(busy), 64'd0);
        chk("t3_no_tx", 64'(n_ts - ts0), 64'd0);
        ser_mute = 1'b0;

        // T4: UART busy when first byte is ready
        uart_hold = 1'b1;
        base = sent.size(); ts0 = n_ts;
        req_data[63:0] = 64'hF0E0D0C0B0A09080;
        req = 4'b0001;
        tick();
        req = '0;
        wait_sv("t4_sv");
        repeat (3) tick();
        chk("t4_withheld",  64'(n_ts - ts0), 64'd0);
        chk("t4_hold_byte", 64'(tx_byte), 64'h80);
        uart_hold = 1'b0;
        tick();
        chk("t4_tx_start", 64'(tx_start), 64'd1);
        chk("t4_byte0",    64'(tx_byte), 64'h80);
        wait_idle("t4_done");
        chk("t4_stream",     stream(base), 64'hF0E0D0C0B0A09080);
        chk("t4_err_sticky", 64'(err), 64'd1);

        // T5: reset during byte 3
        base = sent.size();
        req_data[191:128] = 64'h0123456789ABCDEF;
        req = 4'b0100;
        tick();
        req = '0;
        wait_sent(base, 4);
        chk("t5_at_byte3", 64'(sent.size() - base), 64'd4);
        chk("t5_grant_pre", 64'(grant_id), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy",      64'(busy), 64'd0);
        chk("t5_err",       64'(err), 64'd0);
        chk("t5_sdata",     ser_data[63:0], 64'd0);
        chk("t5_tx_byte",   64'(tx_byte), 64'd0);
        chk("t5_grant",     64'(grant_id), 64'd0);
        chk("t5_pulses",    64'({ack, ser_start, ser_next, tx_start}), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // T6: restart from byte 0, spurious ser_valid during TX
        base = sent.size();
        req_data[63:0] = 64'h0123456789ABCDEF;
        req = 4'b0001;
        tick();
        chk("t6_ack", 64'(ack), 64'h1);
        req = '0;
        wait_sent(base, 2);
        repeat (3) tick();
        inject_aa = 1'b1;
        tick();
        inject_aa = 1'b0;
        wait_idle("t6_done");
        chk("t6_count",  64'(sent.size() - base), 64'd8);
        chk("t6_stream", stream(base), 64'h0123456789ABCDEF);
        chk("t6_err",    64'(err), 64'd0);
        chk("tx_byte_stable", 64'(stab_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
